oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma_pkg.sv | 19 +
 rtl/oam_dma.sv | 105 ++++++++++
 tb/tb_oam_dma.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_pkg.sv
// Shared definitions for the OAM DMA engine: FSM state encoding and the
// two fixed bus addresses the engine decodes or drives.
package oam_dma_pkg;

    // Transfer sequencer states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

    // CPU-visible trigger register address.
    localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
    // Sprite memory data port every fetched byte is written to.
    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to the trigger register halts the core and
// copies one 256-byte page to the sprite data port as 256 read/write pairs.
// Reads always land on even (get) cycles; a single ALIGN cycle is inserted
// when the HALT cycle itself falls on an even cycle.
//
// Bus handshake: there is no ready/valid on the system bus. When dma_own=1
// the bus mux passes bus_addr/bus_rw/bus_wdata to the bus for exactly that
// cycle, and read data on bus_rdata is taken at the end of a READ cycle.
// The CPU is held off by cpu_ready=0 for the whole transfer.
import oam_dma_pkg::*;

module oam_dma (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rw,
    input  logic [7:0]  bus_rdata,
    output logic        cpu_ready,
    output logic        dma_own,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_rw,
    output logic        busy
);

    dma_state_t state;
    dma_state_t state_nxt;
    logic [7:0] page;
    logic [7:0] cnt;
    logic [7:0] data_q;
    logic       parity;   // 0 = get (even) cycle, 1 = put (odd) cycle
    logic       trigger;

    // Next-state and output decode; every output is fully defined per state.
    always_comb begin
        state_nxt = state;
        cpu_ready = 1'b0;
        busy      = 1'b1;
        dma_own   = 1'b0;
        bus_addr  = 16'h0000;
        bus_wdata = 8'h00;
        bus_rw    = 1'b0;
        trigger   = 1'b0;
        case (state)
            IDLE: begin
                cpu_ready = 1'b1;
                busy      = 1'b0;
                // cpu_ready is 1 only here, so IDLE alone qualifies the trigger.
                trigger   = cpu_rw && (cpu_addr == OAMDMA_ADDR);
                if (trigger) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
                // Next cycle must be a get cycle for READ; if it is not, burn one.
                state_nxt = parity ? READ : ALIGN;
            end
            ALIGN: begin
                state_nxt = READ;
            end
            READ: begin
                dma_own   = 1'b1;
                bus_addr  = {page, cnt};
                state_nxt = WRITE;
            end
            WRITE: begin
                dma_own   = 1'b1;
                bus_rw    = 1'b1;
                bus_addr  = OAMDATA_ADDR;
                bus_wdata = data_q;
                state_nxt = (cnt == 8'hFF) ? IDLE : READ;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, parity, page/counter and fetched-byte registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= 8'h00;
            page   <= 8'h00;
            data_q <= 8'h00;
            parity <= 1'b0;
        end else begin
            state  <= state_nxt;
            parity <= ~parity;
            if (trigger) begin
                page <= cpu_wdata;
                cnt  <= 8'h00;
            end
            if (state == READ) begin
                data_q <= bus_rdata;
            end
            if (state == WRITE) begin
                // Wraps to 0 on the final write, ready for the next transfer.
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: a byte-wide memory model answers DMA reads, expected read
// addresses and written bytes are queued at each trigger and consumed by a
// bus monitor, and halt length is measured from cpu_ready.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rw;
    logic [7:0]  bus_rdata;
    logic        cpu_ready;
    logic        dma_own;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_rw;
    logic        busy;

    logic [7:0]  mem [0:65535];
    logic [15:0] exp_rd_q[$];
    logic [7:0]  exp_wr_q[$];

    int          n_cmp  = 0;
    int          n_err  = 0;
    int          wr_cnt = 0;
    bit          mon_en = 1'b0;
    bit          abort  = 1'b0;
    logic        tb_par;

    oam_dma dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rw    (cpu_rw),
        .bus_rdata (bus_rdata),
        .cpu_ready (cpu_ready),
        .dma_own   (dma_own),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rw    (bus_rw),
        .busy      (busy)
    );

    // Clock
    always #5 clk = ~clk;

    // Memory model returns the byte at the current bus address.
    assign bus_rdata = mem[bus_addr];

    // Reference get/put parity: 0 in the first cycle after reset, then toggles.
    always @(posedge clk) begin
        if (!reset_n) tb_par <= 1'b0;
        else          tb_par <= ~tb_par;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (mon_en) begin
            check("busy_vs_ready", 32'(busy), 32'(!cpu_ready));
            if (dma_own && !bus_rw) begin
                if (!abort) begin
                    check("rd_expected", 32'(exp_rd_q.size() != 0), 32'd1);
                    if (exp_rd_q.size() != 0) check("rd_addr", 32'(bus_addr), 32'(exp_rd_q.pop_front()));
                    check("rd_on_get", 32'(tb_par), 32'd0);
                end
            end else if (dma_own && bus_rw) begin
                check("wr_expected", 32'(exp_wr_q.size() != 0), 32'd1);
                if (exp_wr_q.size() != 0) begin
                    check("wr_addr", 32'(bus_addr), 32'h2004);
                    check("wr_data", 32'(bus_wdata), 32'(exp_wr_q.pop_front()));
                end
                wr_cnt++;
            end else begin
                check("idle_bus", 32'({bus_addr, bus_wdata, bus_rw}), 32'd0);
            end
        end
    end

    // Trigger so the HALT cycle has the requested parity; queue expectations.
    task automatic start_dma(input logic [7:0] page, input bit halt_even);
        int guard = 0;
        while (tb_par != logic'(halt_even) && guard < 4) begin
            @(posedge clk); #1;
            guard++;
        end
        check("trig_ready", 32'(cpu_ready), 32'd1);
        for (int i = 0; i < 256; i++) begin
            exp_rd_q.push_back({page, 8'(i)});
            exp_wr_q.push_back(mem[{page, 8'(i)}]);
        end
        wr_cnt    = 0;
        cpu_rw    = 1'b1;
        cpu_addr  = 16'h4014;
        cpu_wdata = page;
        @(posedge clk); #1;
        cpu_rw    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
    endtask

    // Count cpu_ready-low cycles; optionally poke a second trigger mid-transfer.
    task automatic wait_done(input int exp_len, input int poke_at, input string tag);
        int n    = 0;
        bit done = 1'b0;
        while (!done && n < 2000) begin
            @(negedge clk);
            if (cpu_ready) begin
                done = 1'b1;
            end else begin
                n++;
                if (n == poke_at) begin
                    cpu_rw = 1'b1; cpu_addr = 16'h4014; cpu_wdata = 8'hA5;
                end else if (n == poke_at + 1) begin
                    cpu_rw = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
                end
            end
        end
        check({tag, "_halt_len"}, 32'(n), 32'(exp_len));
        check({tag, "_rd_left"}, 32'(exp_rd_q.size()), 32'd0);
        check({tag, "_wr_left"}, 32'(exp_wr_q.size()), 32'd0);
        check({tag, "_wr_count"}, 32'(wr_cnt), 32'd256);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        exp_rd_q.delete();
        exp_wr_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        bit         he;
        logic [7:0] pg;
        int         g;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[{8'h03, 8'(i)}] = 8'(i) ^ 8'h5A;

        // Reset block
        reset_n = 1'b0; cpu_rw = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_cpu_ready", 32'(cpu_ready), 32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_dma_own",   32'(dma_own),   32'd0);
        check("rst_bus_addr",  32'(bus_addr),  32'd0);
        check("rst_bus_wdata", 32'(bus_wdata), 32'd0);
        check("rst_bus_rw",    32'(bus_rw),    32'd0);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Page 02, HALT on odd cycle: no ALIGN, 513 halted cycles.
        start_dma(8'h02, 1'b0);
        wait_done(513, -1, "p02_odd");

        // Page 02, HALT on even cycle: one ALIGN, 514 halted cycles.
        start_dma(8'h02, 1'b1);
        wait_done(514, -1, "p02_even");

        // Page 03 pattern, with an ignored second trigger mid-transfer.
        start_dma(8'h03, 1'b0);
        wait_done(513, 50, "p03_pattern");

        // Page FF ends at FFFF; a following page must start at cnt 0.
        start_dma(8'hFF, 1'b1);
        wait_done(514, -1, "pFF");
        repeat (4) @(posedge clk);
        #1;
        start_dma(8'h01, 1'b0);
        wait_done(513, -1, "p01_after_FF");

        // Reset at byte 100 aborts the transfer.
        he = 1'($urandom_range(0, 1));
        start_dma(8'h04, he);
        g = 0;
        while (wr_cnt < 100 && g < 400) begin
            @(posedge clk); #1;
            g++;
        end
        check("abort_reached", 32'(wr_cnt), 32'd100);
        abort = 1'b1;
        exp_rd_q.delete();
        exp_wr_q.delete();
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_cpu_ready", 32'(cpu_ready), 32'd1);
        check("abort_busy",      32'(busy),      32'd0);
        abort = 1'b0;
        repeat (20) @(negedge clk);
        @(posedge clk); #1;
        start_dma(8'h07, 1'b0);
        wait_done(513, -1, "p07_after_abort");

        // CPU read of 4014 and write of 4015 do not trigger.
        cpu_rw = 1'b0; cpu_addr = 16'h4014; cpu_wdata = 8'h02;
        @(posedge clk); #1;
        cpu_rw = 1'b1; cpu_addr = 16'h4015;
        @(posedge clk); #1;
        cpu_rw = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("notrig_ready", 32'(cpu_ready), 32'd1);
            check("notrig_busy",  32'(busy),      32'd0);
        end
        @(posedge clk); #1;

        // Random pages and HALT parities.
        for (int k = 0; k < 3; k++) begin
            pg = 8'($urandom_range(0, 255));
            he = 1'($urandom_range(0, 1));
            start_dma(pg, he);
            wait_done(he ? 514 : 513, -1, "rand");
        end

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
